// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I core types and constants
package rv32_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

    localparam logic [31:0] RV32_NOP         = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - RV32I fetch stage: PC register, single-request imem port, fetch buffer
module pc_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_o,
    input  logic [31:0] pc_plus4_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         if_valid;
    logic [31:0]  if_pc;
    logic [31:0]  if_instr;
    logic         granted;
    logic         returned;

    assign granted  = (state == S_REQ)  && imem_gnt_i;
    assign returned = (state == S_WAIT) && imem_rvalid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_REQ;
            S_REQ: begin
                if (imem_gnt_i) begin
                    state_nxt = redirect_i ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    state_nxt = imem_rvalid_i ? S_REQ : S_DRAIN;
                end else if (imem_rvalid_i) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_i || if_ready_i) begin
                    state_nxt = S_REQ;
                end
            end
            // A redirect here only retargets pc; the drained response still ends the drain,
            // otherwise a redirect coincident with rvalid would wait forever.
            S_DRAIN: begin
                if (imem_rvalid_i) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= RV32_NOP;
        end else begin
            if (redirect_i) begin
                pc <= {redirect_pc_i[31:2], 2'b00};
            end else if (granted) begin
                pc <= pc_plus4_i;
            end

            if (granted) begin
                req_pc <= pc;
            end

            // Redirect squashes the buffer even if decode handshakes on the same edge
            if (redirect_i) begin
                if_valid <= 1'b0;
            end else if (returned) begin
                if_valid <= 1'b1;
                if_pc    <= req_pc;
                if_instr <= imem_rdata_i;
            end else if ((state == S_HOLD) && if_ready_i) begin
                if_valid <= 1'b0;
            end
        end
    end

    assign pc_o        = pc;
    assign imem_addr_o = pc;
    assign imem_req_o  = (state == S_REQ);
    assign if_valid_o  = if_valid;
    assign if_pc_o     = if_pc;
    assign if_instr_o  = if_instr;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_o, pc_plus4_i, imem_addr_o, imem_rdata_i, redirect_pc_i, if_pc_o, if_instr_o;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i, redirect_i, if_valid_o, if_ready_i;

    logic [31:0] pc2, pc2_plus4, addr2, ifpc2, ifinstr2;
    logic        req2, v2;

    always #5 clk = ~clk;

    assign pc_plus4_i = pc_o + 32'd4;
    assign pc2_plus4  = pc2 + 32'd4;

    pc_fetch dut (
        .clk(clk), .rst_n(rst_n), .pc_o(pc_o), .pc_plus4_i(pc_plus4_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .if_valid_o(if_valid_o), .if_ready_i(if_ready_i), .if_pc_o(if_pc_o), .if_instr_o(if_instr_o)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .pc_o(pc2), .pc_plus4_i(pc2_plus4),
        .imem_req_o(req2), .imem_addr_o(addr2), .imem_gnt_i(1'b1),
        .imem_rvalid_i(1'b1), .imem_rdata_i(32'h1234_5678),
        .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .if_valid_o(v2), .if_ready_i(1'b1), .if_pc_o(ifpc2), .if_instr_o(ifinstr2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return 32'h5A00_0013 + (a << 8);
    endfunction

    // Memory model: grants whenever enabled, returns data the cycle after the grant
    bit          gnt_en = 1'b1, stall_rv = 1'b0, keep_pend = 1'b0;
    bit          pend = 1'b0, last_grant = 1'b0;
    logic [31:0] paddr = '0, last_addr = '0;

    always @(negedge clk) begin
        if (!rst_n && !keep_pend) begin
            pend       = 1'b0;
            last_grant = 1'b0;
        end
        if (imem_rvalid_i) pend = 1'b0;
        if (last_grant) begin
            pend  = 1'b1;
            paddr = last_addr;
        end
        imem_rvalid_i = pend && !stall_rv;
        imem_rdata_i  = imem_rvalid_i ? memword(paddr) : 32'h0;
        imem_gnt_i    = imem_req_o && gnt_en;
        last_grant    = imem_gnt_i;
        last_addr     = imem_addr_o;
    end

    int          cyc = 0;
    logic [31:0] gq[$], dpc[$], dins[$], wq[$], wdq[$];
    int          gcyc[$];

    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            if (imem_req_o && imem_gnt_i) begin
                gq.push_back(imem_addr_o);
                gcyc.push_back(cyc);
            end
            if (if_valid_o && if_ready_i && !redirect_i) begin
                dpc.push_back(if_pc_o);
                dins.push_back(if_instr_o);
            end
            if (req2) wq.push_back(addr2);
            if (v2)   wdq.push_back(ifpc2);
        end
    end

    task automatic drive_pt();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_q();
        gq.delete(); gcyc.delete(); dpc.delete(); dins.delete(); wq.delete(); wdq.delete();
    endtask

    task automatic do_reset(input bit ready);
        drive_pt();
        rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        if_ready_i = ready; gnt_en = 1'b1; stall_rv = 1'b0; keep_pend = 1'b0;
        drive_pt();
        clear_q();
        rst_n = 1'b1;
    endtask

    task automatic wait_deliv(input int n, input string tag);
        int k = 0;
        while (dpc.size() < n && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, dpc.size(), n);
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!if_valid_o && k < 100) begin
            drive_pt();
            k++;
        end
        check(tag, {31'd0, if_valid_o}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; if_ready_i = 1'b1;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        drive_pt();
        drive_pt();
        check("rst_pc",       pc_o,        32'h0);
        check("rst_addr",     imem_addr_o, 32'h0);
        check("rst_req",      {31'd0, imem_req_o}, 32'd0);
        check("rst_valid",    {31'd0, if_valid_o}, 32'd0);
        check("rst_if_pc",    if_pc_o,     32'h0);
        check("rst_if_instr", if_instr_o,  32'h0000_0013);
        check("rst_wrap_pc",  pc2,         32'hFFFF_FFFC);
        clear_q();
        rst_n = 1'b1;

        // Back-to-back fetch at full speed
        wait_deliv(3, "t1_count");
        if (dpc.size() >= 3 && gq.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("t1_gnt_addr%0d", i), gq[i],   32'(4 * i));
                check($sformatf("t1_if_pc%0d", i),    dpc[i],  32'(4 * i));
                check($sformatf("t1_if_instr%0d", i), dins[i], memword(32'(4 * i)));
            end
            check("t1_spacing01", 32'(gcyc[1] - gcyc[0]), 32'd3);
            check("t1_spacing12", 32'(gcyc[2] - gcyc[1]), 32'd3);
        end
        check("t5_wrap_req_n", 32'(wq.size() >= 2), 32'd1);
        if (wq.size() >= 2 && wdq.size() >= 2) begin
            check("t5_wrap_addr0", wq[0],  32'hFFFF_FFFC);
            check("t5_wrap_addr1", wq[1],  32'h0);
            check("t5_wrap_ifpc0", wdq[0], 32'hFFFF_FFFC);
            check("t5_wrap_ifpc1", wdq[1], 32'h0);
        end

        // Decode stall in S_HOLD
        do_reset(1'b0);
        wait_valid("t2_valid");
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", {31'd0, if_valid_o}, 32'd1);
            check("t2_hold_pc",    if_pc_o,    32'h0);
            check("t2_hold_instr", if_instr_o, memword(32'h0));
            check("t2_hold_req",   {31'd0, imem_req_o}, 32'd0);
            drive_pt();
        end
        if_ready_i = 1'b1;
        drive_pt();
        check("t2_after_valid", {31'd0, if_valid_o}, 32'd0);
        check("t2_after_req",   {31'd0, imem_req_o}, 32'd1);
        check("t2_after_addr",  imem_addr_o, 32'h4);

        // Redirect coincident with grant for 0x8
        do_reset(1'b1);
        begin
            int k = 0;
            while (!(imem_req_o && imem_addr_o == 32'h8) && k < 100) begin
                drive_pt();
                k++;
            end
            check("t3_reach_8", imem_addr_o, 32'h8);
        end
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        drive_pt();
        redirect_i = 1'b0;
        check("t3_pc_target", pc_o, 32'h100);
        check("t3_drain_req", {31'd0, imem_req_o}, 32'd0);
        wait_deliv(3, "t3_count");
        if (dpc.size() >= 3 && gq.size() >= 4) begin
            check("t3_if_pc1",    dpc[1],  32'h4);
            check("t3_if_pc2",    dpc[2],  32'h100);
            check("t3_if_instr2", dins[2], memword(32'h100));
            check("t3_gnt3",      gq[3],   32'h100);
        end

        // Redirect to unaligned target while buffer handshakes
        do_reset(1'b1);
        wait_valid("t4_valid");
        redirect_i = 1'b1; redirect_pc_i = 32'h203;
        drive_pt();
        redirect_i = 1'b0;
        check("t4_valid_squash", {31'd0, if_valid_o}, 32'd0);
        check("t4_pc",           pc_o,        32'h200);
        check("t4_req",          {31'd0, imem_req_o}, 32'd1);
        check("t4_addr",         imem_addr_o, 32'h200);
        wait_deliv(1, "t4_count");
        if (dpc.size() >= 1) begin
            check("t4_if_pc",    dpc[0],  32'h200);
            check("t4_if_instr", dins[0], memword(32'h200));
        end

        // Asynchronous reset while waiting for data; stale rvalid after release
        do_reset(1'b1);
        wait_deliv(1, "t6_first");
        drive_pt();
        stall_rv = 1'b1;
        begin
            int k = 0;
            while (gq.size() < 2 && k < 100) begin
                drive_pt();
                k++;
            end
            check("t6_second_gnt", 32'(gq.size()), 32'd2);
        end
        keep_pend = 1'b1;
        rst_n = 1'b0;
        #1;
        check("t6_async_pc",    pc_o,       32'h0);
        check("t6_async_req",   {31'd0, imem_req_o}, 32'd0);
        check("t6_async_instr", if_instr_o, 32'h0000_0013);
        drive_pt();
        clear_q();
        rst_n = 1'b1; stall_rv = 1'b0; keep_pend = 1'b0;
        wait_deliv(2, "t6_count");
        if (dpc.size() >= 2) begin
            check("t6_if_pc0",    dpc[0],  32'h0);
            check("t6_if_instr0", dins[0], memword(32'h0));
            check("t6_if_pc1",    dpc[1],  32'h4);
            check("t6_if_instr1", dins[1], memword(32'h4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch stage of the RV32I core: owns the program-counter register and the single-entry fetch buffer in front of decode. It drives the current PC to the external PC+4 `adder_32` instance and takes the sum back as the sequential next PC. It issues one instruction-memory request at a time and hands each returned word to decode over a valid/ready handshake. Branch and jump redirects from execute override the sequential path and squash in-flight fetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pc_o` out 32: PC register; wired to `adder_32.value1`. `value2` is tied to 32'd4.
- `pc_plus4_i` in 32: `adder_32.out_value`.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: fetch address; always equal to `pc_o`.
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: read data valid. Arrives no earlier than the cycle after the grant.
- `imem_rdata_i` in 32: instruction word.
- `redirect_i` in 1: taken branch or jump.
- `redirect_pc_i` in 32: redirect target. Bits [1:0] are ignored and forced to 2'b00.
- `if_valid_o` out 1: fetch buffer holds an instruction for decode.
- `if_ready_i` in 1: decode accepts.
- `if_pc_o` out 32: PC of the buffered instruction.
- `if_instr_o` out 32: buffered instruction.

## Operation
- FSM states: `S_IDLE`, `S_REQ`, `S_WAIT`, `S_HOLD`, `S_DRAIN`. The reset state is `S_IDLE`.
- `S_IDLE`: no request. Next state is always `S_REQ`; this state is occupied only in the first cycle after reset release.
- `S_REQ`: `imem_req_o`=1.
  - On `imem_gnt_i`: load `pc` from `pc_plus4_i` and go to `S_WAIT`.
  - Otherwise hold state; `pc` and the address stay stable.
- `S_WAIT`: waiting for data. On `imem_rvalid_i`:
  - capture `if_instr_o` from `imem_rdata_i`;
  - capture `if_pc_o` from `pc - 4`, the granted address, held in a separate `req_pc` register;
  - set `if_valid_o`;
  - go to `S_HOLD`.
- `S_HOLD`: `if_valid_o`=1. On `if_valid_o & if_ready_i`, clear `if_valid_o` and go to `S_REQ`. The buffer contents stay stable while stalled.
- Redirect has priority over every other event in every state. It loads `pc` from `{redirect_pc_i[31:2],2'b00}` and clears `if_valid_o` on the next edge. Next state depends on the current state:
  - `S_REQ` without grant: stay in `S_REQ`. The request address changes to the target; the memory tolerates this.
  - `S_REQ` with grant in the same cycle: go to `S_DRAIN`. The granted request is outstanding and the target overrides `pc_plus4_i`.
  - `S_WAIT` without rvalid: go to `S_DRAIN`.
  - `S_WAIT` with rvalid in the same cycle: discard the data and go to `S_REQ`.
  - `S_HOLD`: discard the buffer, even if decode handshakes in the same cycle, and go to `S_REQ`.
  - `S_DRAIN`: update `pc` and stay in `S_DRAIN`.
  - `S_IDLE`: update `pc` and go to `S_REQ`.
- `S_DRAIN`: no request. On `imem_rvalid_i`, discard the data and go to `S_REQ`.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- At most one memory request is outstanding. No response is ever presented to decode after a redirect that followed its request.

## Timing
- Reset values:
  - `pc_o` and `imem_addr_o`: `RESET_PC`.
  - `imem_req_o`: 0.
  - `if_valid_o`: 0.
  - `if_pc_o`: 0.
  - `if_instr_o`: 32'h0000_0013 (NOP).
- Reset is asynchronous. Asserting it mid-fetch returns to `S_IDLE` immediately, and any later `imem_rvalid_i` for the abandoned request is ignored. The memory side is reset by the same `rst_n`.
- `imem_req_o` and `if_valid_o` are decoded from state/registers only, with no combinational path from any input.
- Minimum latency with grant and rvalid on the earliest cycles: request at cycle N, rvalid at N+1, `if_valid_o` at N+2. The next request is at N+3, i.e. 3 cycles per instruction.
- Redirect at cycle N: `pc_o` equals the target at N+1; the first request to the target is at N+1, or after the drain completes.

## Structure
- Shared package `rv32_pkg`:
  - enum `fetch_state_t`;
  - `RV32_NOP` = 32'h0000_0013;
  - `INSTR_BYTES` = 4;
  - default `RESET_PC`.
- No sub-module. The `adder_32` instance stays in the parent and is connected through `pc_o`/`pc_plus4_i`. The block is one FSM plus the `pc`, `req_pc` and fetch-buffer registers.

## Test plan
- Reset release, memory granting and returning every cycle, decode always ready → requests at 0x0, 0x4, 0x8, each 3 cycles apart; `if_pc_o`/`if_instr_o` match the memory model.
- `if_ready_i`=0 for 5 cycles in `S_HOLD` → `if_valid_o`, `if_pc_o`, `if_instr_o` stable; no `imem_req_o` until the handshake completes.
- Redirect to 0x100 in the same cycle as a grant for 0x8 → rvalid for 0x8 discarded in `S_DRAIN`; the next request is to 0x100; decode never sees 0x8.
- Redirect to 0x203 while in `S_HOLD` with `if_ready_i`=1 → buffer squashed, the next request address is 0x200, `if_valid_o`=0 for that cycle.
- `RESET_PC`=32'hFFFF_FFFC → second fetch address is 0x0.
- `rst_n` asserted while in `S_WAIT`, rvalid arrives after release → data ignored; fetch restarts at `RESET_PC`.
